// File: rtl/uart_word_tx_if.sv
// Push-side handshake of uart_word_tx: a 1-4 byte word plus its byte count, taken atomically.
interface uart_word_tx_if;
    logic        PUSH_VALID;
    logic [31:0] PUSH_DATA;
    logic [2:0]  PUSH_BYTES;
    logic        PUSH_READY;

    modport master (output PUSH_VALID, PUSH_DATA, PUSH_BYTES, input PUSH_READY);
    modport slave  (input PUSH_VALID, PUSH_DATA, PUSH_BYTES, output PUSH_READY);
endinterface

// File: rtl/uart_word_tx.sv
// Word-wide console UART: queues 1-4 byte pushes in a circular byte FIFO and sends 8N1/8N2 frames.
// Latency: push at edge k updates LEVEL after k; start bit falls at k+1; frame = (9+STOP_BITS)*CLKS_PER_BIT.
// Backpressure: PUSH_READY low while registered free space < PUSH_BYTES; a word is never split.
module uart_word_tx #(
    parameter int unsigned DEPTH        = 512,
    parameter int unsigned CLKS_PER_BIT = 2604,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    uart_word_tx_if.slave              push,
    output logic [$clog2(DEPTH+1)-1:0] LEVEL,
    output logic                       BUSY,
    output logic                       BAD_LEN,
    output logic                       UART_TX
);
    localparam int unsigned PW        = $clog2(DEPTH);
    localparam int unsigned LW        = $clog2(DEPTH + 1);
    localparam int unsigned STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
    localparam int unsigned CW        = $clog2(STOP_CLKS);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [LW-1:0] level_q, level_d;
    logic          bad_q, bad_d;
    logic [7:0]    mem_q [DEPTH];

    logic          len_bad;
    logic [LW-1:0] free_slots;
    logic          push_fire;
    logic          push_ok;
    logic [2:0]    push_n;
    logic [31:0]   aligned;
    logic          pop;
    logic          load;

    assign len_bad         = (push.PUSH_BYTES == 3'd0) || (push.PUSH_BYTES > 3'd4);
    assign free_slots      = LW'(DEPTH) - level_q;
    assign push.PUSH_READY = len_bad || (free_slots >= LW'(push.PUSH_BYTES));
    assign push_fire       = push.PUSH_VALID && push.PUSH_READY;
    assign push_ok         = push_fire && !len_bad;
    assign push_n          = push_ok ? push.PUSH_BYTES : 3'd0;

    // Left-justify the word so slot i always takes byte lane 3-i, MSB first.
    assign aligned = push.PUSH_DATA << (6'd32 - {push.PUSH_BYTES, 3'b000});

    always_ff @(posedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (push_ok && (i < int'(push.PUSH_BYTES))) begin
                mem_q[tail_q + PW'(i)] <= aligned[31-8*i -: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        load    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                load = (level_q != '0);
            end
            START: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == CW'(STOP_CLKS - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    load    = (level_q != '0);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Loading straight from STOP gives back-to-back frames with no idle bit.
        if (load) begin
            pop     = 1'b1;
            state_d = START;
            cnt_d   = '0;
            bit_d   = '0;
            shift_d = mem_q[head_q];
            tx_d    = 1'b0;
        end
    end

    assign head_d  = head_q + PW'(pop);
    assign tail_d  = tail_q + PW'(push_n);
    assign level_d = level_q + LW'(push_n) - LW'(pop);
    assign bad_d   = bad_q | (push_fire && len_bad);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
            bad_q   <= bad_d;
        end
    end

    assign LEVEL   = level_q;
    assign BUSY    = (state_q != IDLE) || (level_q != '0);
    assign BAD_LEN = bad_q;
    assign UART_TX = tx_q;
endmodule
